// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: memory-side responder for the CPU bus (MAR / MBR_W / write / MBR_R).
// Boot sequence: CLR zeroes addresses 0..CLEAR_WORDS-1, LOAD accepts a program over a
// valid/ready loader port, RUN releases the CPU from reset and serves reads and writes.
// Optional feature macro: MEM_ACCESS_STATS_EN (saturating count of accepted CPU writes).
module cpu_mem_responder #(
    parameter int unsigned BITS_DATA   = 32,
    parameter int unsigned BITS_ADDR   = 16,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned CLEAR_WORDS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITS_ADDR-1:0] MAR,
    input  logic [BITS_DATA-1:0] MBR_W,
    input  logic                 write,
    output logic [BITS_DATA-1:0] MBR_R,
    output logic                 cpu_reset,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [BITS_ADDR-1:0] load_addr,
    input  logic [BITS_DATA-1:0] load_data,
    input  logic                 load_done,
    output logic                 oob_err,
    output logic [15:0]          wr_count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH itself is representable even when DEPTH == 2**BITS_ADDR.
    localparam logic [BITS_ADDR:0] DEPTH_X  = DEPTH[BITS_ADDR:0];
    localparam logic [IDX_W-1:0]   CLR_LAST = IDX_W'(CLEAR_WORDS - 1);

    typedef enum logic [1:0] {
        CLR  = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } stateType;

    stateType             state;
    logic [IDX_W-1:0]     clrPtr;
    logic [BITS_DATA-1:0] mem [DEPTH];

    logic marInRange;
    logic loadInRange;
    logic clrWrite;
    logic loadWrite;
    logic cpuWrite;
    logic cpuOob;

    // Full-width unsigned compares; upper address bits never alias into the array.
    always_comb begin
        marInRange  = {1'b0, MAR} < DEPTH_X;
        loadInRange = {1'b0, load_addr} < DEPTH_X;
        clrWrite    = !reset && (state == CLR);
        loadWrite   = !reset && (state == LOAD) && load_valid && loadInRange;
        cpuWrite    = !reset && (state == RUN) && write && marInRange;
        cpuOob      = !reset && (state == RUN) && write && !marInRange;
    end

    // Storage write port: only one source can be active per state, so the priority is moot.
    always_ff @(posedge clk) begin
        if (clrWrite) begin
            mem[clrPtr] <= '0;
        end else if (loadWrite) begin
            mem[load_addr[IDX_W-1:0]] <= load_data;
        end else if (cpuWrite) begin
            mem[MAR[IDX_W-1:0]] <= MBR_W;
        end
    end

    // Boot FSM with registered cpu_reset that drops on the edge entering RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLR;
            clrPtr    <= '0;
            oob_err   <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            unique case (state)
                CLR: begin
                    cpu_reset <= 1'b1;
                    clrPtr    <= clrPtr + 1'b1;
                    if (clrPtr == CLR_LAST) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_done) begin
                        state     <= RUN;
                        cpu_reset <= 1'b0;
                    end else begin
                        cpu_reset <= 1'b1;
                    end
                end
                RUN: begin
                    cpu_reset <= 1'b0;
                    if (cpuOob) begin
                        oob_err <= 1'b1;
                    end
                end
                default: begin
                    state     <= CLR;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

    // Read data and loader handshake; both are held inactive while reset is asserted.
    always_comb begin
        MBR_R      = '0;
        load_ready = !reset && (state == LOAD);
        if (!reset && (state == RUN) && marInRange) begin
            MBR_R = mem[MAR[IDX_W-1:0]];
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    // Saturating count of accepted in-range CPU writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
        end else if (cpuWrite && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
        end
    end
`else
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: random loader and CPU traffic against an
// associative-array memory model, plus the boot/reset boundary cases.
module tb_cpu_mem_responder;

    localparam int DEPTH = 4096;
    localparam int CLEAR = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] MAR;
    logic [31:0] MBR_W;
    logic        write;
    logic [31:0] MBR_R;
    logic        cpu_reset;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_addr;
    logic [31:0] load_data;
    logic        load_done;
    logic        oob_err;
    logic [15:0] wr_count;

    cpu_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .MAR        (MAR),
        .MBR_W      (MBR_W),
        .write      (write),
        .MBR_R      (MBR_R),
        .cpu_reset  (cpu_reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_done  (load_done),
        .oob_err    (oob_err),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    logic [31:0] model [int];
    int          nCompared   = 0;
    int          nMismatched = 0;
    int          expWr       = 0;
    logic        expOob      = 1'b0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] expWrCount();
`ifdef MEM_ACCESS_STATS_EN
        return (expWr > 65535) ? 32'h0000FFFF : 32'(expWr);
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] expRead(input logic [15:0] a);
        if (int'(a) >= DEPTH) return 32'h0;
        return model[int'(a)];
    endfunction

    // Reads one address in RUN (only addresses the model knows, or out of range).
    task automatic readCheck(input string tag, input logic [15:0] a);
        MAR   = a;
        write = 1'b0;
        #1;
        if (int'(a) >= DEPTH || model.exists(int'(a))) checkVal(tag, MBR_R, expRead(a));
        tick();
    endtask

    task automatic modelReset;
        for (int i = 0; i < CLEAR; i++) model[i] = 32'h0;
        expWr  = 0;
        expOob = 1'b0;
    endtask

    // CLR must last exactly CLEAR cycles with the CPU held and the loader not ready.
    task automatic clrPhase;
        for (int i = 0; i < CLEAR; i++) begin
            #1;
            checkVal("clr_ready", 32'(load_ready), 32'h0);
            checkVal("clr_cpu_reset", 32'(cpu_reset), 32'h1);
            tick();
        end
        #1;
        checkVal("load_ready_up", 32'(load_ready), 32'h1);
        checkVal("load_cpu_reset", 32'(cpu_reset), 32'h1);
    endtask

    task automatic loadWord(input logic [15:0] a, input logic [31:0] d);
        if ($urandom_range(3) == 0) tick();
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        #1;
        checkVal("load_ready", 32'(load_ready), 32'h1);
        tick();
        load_valid = 1'b0;
        if (int'(a) < DEPTH) model[int'(a)] = d;
    endtask

    initial begin
        logic [15:0] a;
        logic        wr;
        logic [31:0] d;

        reset      = 1'b1;
        MAR        = '0;
        MBR_W      = '0;
        write      = 1'b0;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        load_done  = 1'b0;

        // First boot: plant known contents, including mem[5]=DEAD for the later reset.
        tick();
        reset = 1'b0;
        modelReset();
        checkVal("rst_oob", 32'(oob_err), 32'h0);
        checkVal("rst_wr_count", 32'(wr_count), 32'h0);
        checkVal("rst_mbr_r", MBR_R, 32'h0);
        clrPhase();
        for (int i = 0; i < 64; i++) loadWord(16'(i), $urandom);
        loadWord(16'd0, 32'h13000005);
        loadWord(16'd1, 32'h0);
        loadWord(16'(DEPTH), 32'h1);
        loadWord(16'd5, 32'hDEAD);
        loadWord(16'd3, $urandom);
        loadWord(16'd3, 32'h33);
        loadWord(16'h0FFF, $urandom);
        loadWord(16'hFFFF, 32'h2);

        // Coincident last word and done: word lands, RUN next cycle.
        load_valid = 1'b1;
        load_addr  = 16'd7;
        load_data  = 32'h77;
        load_done  = 1'b1;
        tick();
        load_valid = 1'b0;
        load_done  = 1'b0;
        model[7]   = 32'h77;
        checkVal("run_cpu_reset", 32'(cpu_reset), 32'h0);
        checkVal("run_load_ready", 32'(load_ready), 32'h0);
        readCheck("boot_word0", 16'd0);
        readCheck("boot_word1", 16'd1);
        readCheck("dup_last_wins", 16'd3);
        readCheck("word7", 16'd7);

        // Loader traffic in RUN is ignored.
        load_valid = 1'b1;
        load_addr  = 16'd7;
        load_data  = 32'h99;
        load_done  = 1'b1;
        tick();
        load_valid = 1'b0;
        load_done  = 1'b0;
        readCheck("run_load_ignored", 16'd7);

        // Single write: old value during the strobe, new value after.
        MAR   = 16'd5;
        MBR_W = 32'hCAFEF00D;
        write = 1'b1;
        #1;
        checkVal("wr_old_value", MBR_R, 32'hDEAD);
        tick();
        write    = 1'b0;
        model[5] = 32'hCAFEF00D;
        expWr++;
        checkVal("wr_new_value", MBR_R, 32'hCAFEF00D);
        checkVal("wr_count_1", 32'(wr_count), expWrCount());

        // Out-of-range write: sticky error, no aliasing, not counted.
        MAR   = 16'hFFFF;
        MBR_W = 32'h12345678;
        write = 1'b1;
        #1;
        checkVal("oob_mbr_r", MBR_R, 32'h0);
        tick();
        write  = 1'b0;
        expOob = 1'b1;
        checkVal("oob_err_set", 32'(oob_err), 32'h1);
        checkVal("oob_wr_count", 32'(wr_count), expWrCount());
        readCheck("oob_no_alias", 16'h0FFF);
        readCheck("oob_no_alias0", 16'd0);
        checkVal("oob_sticky", 32'(oob_err), 32'h1);

        // Random CPU traffic; write may stay high across consecutive iterations.
        for (int i = 0; i < 120; i++) begin
            int r;
            r  = int'($urandom_range(9));
            a  = (r < 2) ? 16'($urandom_range(16'hFFFF, DEPTH)) :
                 (r == 2) ? 16'h0FFF : 16'($urandom_range(63));
            wr = 1'($urandom_range(1));
            d  = $urandom;
            MAR   = a;
            MBR_W = d;
            write = wr;
            #1;
            checkVal("rnd_read", MBR_R, expRead(a));
            checkVal("rnd_oob", 32'(oob_err), 32'(expOob));
            tick();
            if (wr) begin
                if (int'(a) < DEPTH) begin
                    model[int'(a)] = d;
                    expWr++;
                end else begin
                    expOob = 1'b1;
                end
            end
            checkVal("rnd_wr_count", 32'(wr_count), expWrCount());
        end
        write = 1'b0;

        // Reset during RUN with a coincident write to a cleared address.
        MAR   = 16'd3;
        MBR_W = 32'h1;
        write = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        write = 1'b0;
        modelReset();
        checkVal("rerst_cpu_reset", 32'(cpu_reset), 32'h1);
        checkVal("rerst_oob", 32'(oob_err), 32'h0);
        checkVal("rerst_wr_count", 32'(wr_count), 32'h0);
        checkVal("rerst_mbr_r", MBR_R, 32'h0);
        clrPhase();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        checkVal("reboot_cpu_reset", 32'(cpu_reset), 32'h0);
        readCheck("reboot_cleared5", 16'd5);
        readCheck("reboot_cleared3", 16'd3);
        for (int i = 0; i < 64; i++) readCheck("reboot_retained", 16'(i));
        readCheck("reboot_top", 16'h0FFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
